// File: rtl/alu_logic_seq_pkg.sv
// Shared opcode constants, FSM encoding and decode helper for the sequential logic ALU.
package alu_logic_seq_pkg;

  localparam logic [3:0] FUN_AND   = 4'b1000;
  localparam logic [3:0] FUN_OR    = 4'b1110;
  localparam logic [3:0] FUN_XOR   = 4'b0110;
  localparam logic [3:0] FUN_NOR   = 4'b0001;
  localparam logic [3:0] FUN_PASSA = 4'b1010;
  localparam logic [3:0] FUN_XNOR  = 4'b1001;
  localparam logic [3:0] FUN_ANDN  = 4'b1011;
  localparam logic [3:0] FUN_CLZ   = 4'b0100;
  localparam logic [3:0] FUN_CLO   = 4'b0101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic logic is_count_op(input logic [3:0] fun);
    return (fun == FUN_CLZ) || (fun == FUN_CLO);
  endfunction

endpackage

// File: rtl/alu_logic_seq_core.sv
// Single-cycle bitwise decoder; count opcodes and unknown codes produce zero here.
module alu_logic_core
  import alu_logic_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       fun,
  output logic [WIDTH-1:0] res
);

  always_comb begin
    res = '0;
    case (fun)
      FUN_AND:   res = a & b;
      FUN_OR:    res = a | b;
      FUN_XOR:   res = a ^ b;
      FUN_NOR:   res = ~(a | b);
      FUN_PASSA: res = a;
      FUN_XNOR:  res = ~(a ^ b);
      FUN_ANDN:  res = a & ~b;
      default:   res = '0;
    endcase
  end

endmodule

// File: rtl/alu_logic_seq.sv
// Handshaked logic ALU: bitwise ops finish in one edge, CLZ/CLO scan A one bit per cycle.
module alu_logic_seq
  import alu_logic_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       fun,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero
);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [CNT_W-1:0] r_cnt;
  logic             r_clo;
  logic [WIDTH-1:0] r_out;
  logic             r_out_zero;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_res;
  logic             w_accept;
  logic             w_term;
  logic             w_last;
  logic [WIDTH-1:0] w_cnt_ext;

  alu_logic_core #(.WIDTH(WIDTH)) u_core (
    .a   (a),
    .b   (b),
    .fun (fun),
    .res (w_res)
  );

  assign w_accept  = in_valid && r_in_ready;
  // r_a is shifted left each SCAN cycle, so its MSB is always A[WIDTH-1-cnt].
  assign w_term    = r_a[WIDTH-1] ^ r_clo;
  assign w_last    = (r_cnt == CNT_W'(WIDTH-1));
  assign w_cnt_ext = WIDTH'(r_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_out       <= '0;
      r_out_zero  <= 1'b1;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (is_count_op(fun)) begin
              r_a     <= a;
              r_clo   <= (fun == FUN_CLO);
              r_cnt   <= '0;
              r_state <= ST_SCAN;
            end else begin
              r_out       <= w_res;
              r_out_zero  <= (w_res == '0);
              r_out_valid <= 1'b1;
              r_state     <= ST_HOLD;
            end
          end
        end
        ST_SCAN: begin
          if (w_term) begin
            r_out       <= w_cnt_ext;
            r_out_zero  <= (r_cnt == '0);
            r_out_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end else if (w_last) begin
            r_out       <= WIDTH'(WIDTH);
            r_out_zero  <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_a   <= r_a << 1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign out_zero  = r_out_zero;

endmodule

// File: tb/tb_alu_logic_seq.sv
// Directed bench for alu_logic_seq at WIDTH=32 and WIDTH=8.
module tb_alu_logic_seq;
  import alu_logic_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        out_ready;

  logic        iv32, ir32, ov32, oz32;
  logic [31:0] a32, b32, o32;
  logic [3:0]  f32;

  logic        iv8, ir8, ov8, oz8;
  logic [7:0]  a8, b8, o8;
  logic [3:0]  f8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_logic_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .fun(f32), .out_valid(ov32), .out_ready(out_ready),
    .out(o32), .out_zero(oz32)
  );

  alu_logic_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .fun(f8), .out_valid(ov8), .out_ready(out_ready),
    .out(o8), .out_zero(oz8)
  );

  typedef struct {
    logic [3:0]  fun;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        ez;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one op from IDLE with out_ready=1 and check result, flag, latency and release.
  task automatic run_op(input bit w8, input string name, input logic [3:0] fun,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input logic ez, input int lat_exp);
    int lat;
    out_ready = 1'b1;
    if (w8) begin iv8 = 1'b1; f8 = fun; a8 = a[7:0]; b8 = b[7:0]; end
    else    begin iv32 = 1'b1; f32 = fun; a32 = a; b32 = b; end
    @(posedge clk); #1;
    iv8 = 1'b0; iv32 = 1'b0;
    a8 = ~a8; b8 = ~b8; f8 = 4'hF;
    a32 = ~a32; b32 = ~b32; f32 = 4'hF;
    lat = 1;
    while (!(w8 ? ov8 : ov32) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, ".lat"}, 64'(lat), 64'(lat_exp));
    check({name, ".out"}, w8 ? 64'(o8) : 64'(o32), 64'(exp));
    check({name, ".zero"}, w8 ? 64'(oz8) : 64'(oz32), 64'(ez));
    @(posedge clk); #1;
    check({name, ".valid_drop"}, w8 ? 64'(ov8) : 64'(ov32), 64'd0);
    check({name, ".ready_back"}, w8 ? 64'(ir8) : 64'(ir32), 64'd1);
  endtask

  initial begin
    int stale;
    reset = 1'b1; out_ready = 1'b1;
    iv32 = 1'b0; a32 = '0; b32 = '0; f32 = '0;
    iv8  = 1'b0; a8  = '0; b8  = '0; f8  = '0;

    vecs.push_back('{FUN_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1});
    vecs.push_back('{FUN_OR,    32'h0F0F0000, 32'h00F0000F, 32'h0FFF000F, 1'b0, 1});
    vecs.push_back('{FUN_XOR,   32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1});
    vecs.push_back('{FUN_NOR,   32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1});
    vecs.push_back('{FUN_NOR,   32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1});
    vecs.push_back('{FUN_PASSA, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1});
    vecs.push_back('{FUN_XNOR,  32'h0F0F0F0F, 32'h00FF00FF, 32'hF00FF00F, 1'b0, 1});
    vecs.push_back('{FUN_ANDN,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00000, 1'b0, 1});
    vecs.push_back('{4'b0011,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1});
    vecs.push_back('{4'b1111,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1});
    vecs.push_back('{FUN_CLZ,   32'h00010000, 32'h0,        32'd15,       1'b0, 17});
    vecs.push_back('{FUN_CLZ,   32'h00000000, 32'h0,        32'd32,       1'b0, 33});
    vecs.push_back('{FUN_CLZ,   32'h80000000, 32'h0,        32'd0,        1'b1, 2});
    vecs.push_back('{FUN_CLZ,   32'h00000001, 32'h0,        32'd31,       1'b0, 33});
    vecs.push_back('{FUN_CLO,   32'hFFFFFFFF, 32'h0,        32'd32,       1'b0, 33});
    vecs.push_back('{FUN_CLO,   32'hFFF00000, 32'h0,        32'd12,       1'b0, 14});
    vecs.push_back('{FUN_CLO,   32'h7FFFFFFF, 32'h0,        32'd0,        1'b1, 2});
    vecs.push_back('{FUN_CLO,   32'hFFFFFFFE, 32'h0,        32'd31,       1'b0, 33});

    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready32", 64'(ir32), 64'd1);
    check("rst.out_valid32", 64'(ov32), 64'd0);
    check("rst.out32", 64'(o32), 64'd0);
    check("rst.out_zero32", 64'(oz32), 64'd1);
    check("rst.in_ready8", 64'(ir8), 64'd1);
    check("rst.out8", 64'(o8), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++)
      run_op(1'b0, $sformatf("vec%0d", i), vecs[i].fun, vecs[i].a, vecs[i].b,
             vecs[i].exp, vecs[i].ez, vecs[i].lat);

    // Backpressure: result must hold and a pending request must wait for IDLE.
    out_ready = 1'b0;
    iv32 = 1'b1; f32 = FUN_AND; a32 = 32'hF0F0F0F0; b32 = 32'hFF00FF00;
    @(posedge clk); #1;
    f32 = FUN_OR; a32 = 32'h0000FFFF; b32 = 32'h00FF0000;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d.out", k), 64'(o32), 64'hF000F000);
      check($sformatf("bp%0d.out_valid", k), 64'(ov32), 64'd1);
      check($sformatf("bp%0d.in_ready", k), 64'(ir32), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp.release_valid", 64'(ov32), 64'd0);
    check("bp.release_ready", 64'(ir32), 64'd1);
    check("bp.release_out", 64'(o32), 64'hF000F000);
    @(posedge clk); #1;
    iv32 = 1'b0;
    check("bp.new_valid", 64'(ov32), 64'd1);
    check("bp.new_out", 64'(o32), 64'h00FFFFFF);
    @(posedge clk); #1;
    check("bp.idle", 64'(ir32), 64'd1);

    // Reset in the middle of HOLD.
    out_ready = 1'b0;
    iv32 = 1'b1; f32 = FUN_PASSA; a32 = 32'hDEADBEEF;
    @(posedge clk); #1;
    iv32 = 1'b0;
    check("rhold.pre_out", 64'(o32), 64'hDEADBEEF);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rhold.out", 64'(o32), 64'd0);
    check("rhold.out_zero", 64'(oz32), 64'd1);
    check("rhold.out_valid", 64'(ov32), 64'd0);
    check("rhold.in_ready", 64'(ir32), 64'd1);
    out_ready = 1'b1;

    // Reset on the 3rd SCAN cycle of CLZ(0): the count must never surface.
    run_op(1'b0, "pre_scan", FUN_PASSA, 32'h12345678, 32'h0, 32'h12345678, 1'b0, 1);
    iv32 = 1'b1; f32 = FUN_CLZ; a32 = 32'h0;
    @(posedge clk); #1;
    iv32 = 1'b0;
    check("rscan.in_ready", 64'(ir32), 64'd0);
    check("rscan.out_hold", 64'(o32), 64'h12345678);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rscan.out", 64'(o32), 64'd0);
    check("rscan.out_valid", 64'(ov32), 64'd0);
    check("rscan.in_ready", 64'(ir32), 64'd1);
    stale = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (ov32) stale++;
    end
    check("rscan.no_stale", 64'(stale), 64'd0);
    run_op(1'b0, "post_rst", FUN_CLZ, 32'h00800000, 32'h0, 32'd8, 1'b0, 10);

    // Narrow instance.
    run_op(1'b1, "w8.clz0", FUN_CLZ, 32'h00, 32'h00, 32'd8, 1'b0, 9);
    run_op(1'b1, "w8.xnor", FUN_XNOR, 32'h0F, 32'h3C, 32'hCC, 1'b0, 1);
    run_op(1'b1, "w8.clo", FUN_CLO, 32'hFF, 32'h00, 32'd8, 1'b0, 9);
    run_op(1'b1, "w8.clz1", FUN_CLZ, 32'h10, 32'h00, 32'd3, 1'b0, 5);
    run_op(1'b1, "w8.unused", 4'b0011, 32'hFF, 32'hFF, 32'h00, 1'b1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
